// File: rtl/range_input_loader_if.sv
// range_input_loader_if: ASCII byte stream feeding the range loader
// Signals: in_valid/in_data/in_last driven by the producer (master),
//          in_ready driven by the loader (slave).
interface range_input_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/range_input_loader.sv
// range_input_loader: parses ASCII "lo-hi" ranges and writes them round-robin into lane memory banks
// Ports: clk, reset (sync, active-high); bus (slave byte stream in_valid/in_ready/in_data/in_last);
//        wr_en/wr_bank/wr_addr/wr_lo/wr_hi (bank write port, lane i owns bank i);
//        range_count (ranges written); done/error/err_code (sticky status: 1 format, 2 overflow, 3 full)
module range_input_loader #(
    parameter  int VALUE_PARALLELISM = 4,
    parameter  int VALUE_WIDTH       = 64,
    parameter  int MEM_DEPTH         = 512,
    parameter  int COUNT_W           = $clog2(VALUE_PARALLELISM * MEM_DEPTH) + 1,
    localparam int BANK_W            = VALUE_PARALLELISM > 1 ? $clog2(VALUE_PARALLELISM) : 1,
    localparam int ADDR_W            = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    range_input_loader_if.slave    bus,
    output logic                   wr_en,
    output logic [BANK_W-1:0]      wr_bank,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [VALUE_WIDTH-1:0] wr_lo,
    output logic [VALUE_WIDTH-1:0] wr_hi,
    output logic [COUNT_W-1:0]     range_count,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code
);
    localparam logic [COUNT_W-1:0] CAP = COUNT_W'(VALUE_PARALLELISM * MEM_DEPTH);

    typedef enum logic [1:0] {LO, HI, DONE, ERR} state_t;

    state_t                 state, n_state;
    logic [VALUE_WIDTH-1:0] acc, n_acc, lo, n_lo, hi_val;
    logic                   dig, n_dig, n_emit, n_done, do_term;
    logic [1:0]             n_code;
    logic [BANK_W-1:0]      bank_ctr;
    logic [ADDR_W-1:0]      addr_ctr;
    logic [VALUE_WIDTH+3:0] wide, prod;
    logic                   take, is_digit, is_ws, is_dash, is_sep;

    assign bus.in_ready = (state == LO) || (state == HI);
    assign take         = bus.in_valid && bus.in_ready;
    assign is_digit     = bus.in_data >= 8'h30 && bus.in_data <= 8'h39;
    assign is_ws        = bus.in_data == 8'h20 || bus.in_data == 8'h0d;
    assign is_dash      = bus.in_data == 8'h2d;
    assign is_sep       = bus.in_data == 8'h2c || bus.in_data == 8'h0a;
    // acc*10 + digit in 4 extra bits; any set upper bit means the value no longer fits
    assign wide         = {4'b0, acc};
    assign prod         = (wide << 3) + (wide << 1) + {{VALUE_WIDTH{1'b0}}, bus.in_data[3:0]};

    always_comb begin
        n_state = state;
        n_acc   = acc;
        n_lo    = lo;
        n_dig   = dig;
        n_emit  = 1'b0;
        n_done  = 1'b0;
        n_code  = 2'd0;
        do_term = 1'b0;
        hi_val  = acc;
        if (take) begin
            if (is_digit) begin
                n_acc  = prod[VALUE_WIDTH-1:0];
                n_dig  = 1'b1;
                n_code = |prod[VALUE_WIDTH+3:VALUE_WIDTH] ? 2'd2 : 2'd0;
            end else if (is_dash) begin
                if (state == LO && dig) begin
                    n_lo    = acc;
                    n_acc   = '0;
                    n_dig   = 1'b0;
                    n_state = HI;
                end else begin
                    n_code = 2'd1;
                end
            end else if (is_sep) begin
                if (state == HI && dig)
                    do_term = 1'b1;
                else if (state == HI || dig)
                    n_code = 2'd1;
            end else if (!is_ws) begin
                n_code = 2'd1;
            end
            // a final byte may close the stream cleanly or leave an open range to terminate implicitly
            if (bus.in_last && n_code == 2'd0) begin
                if (n_state == LO && !n_dig) begin
                    n_done = 1'b1;
                end else if (n_state == HI && n_dig) begin
                    do_term = 1'b1;
                    n_done  = 1'b1;
                end else begin
                    n_code = 2'd1;
                end
            end
            if (do_term && n_code == 2'd0) begin
                hi_val = n_acc;
                if (lo > n_acc) begin
                    n_code = 2'd1;
                end else if (range_count == CAP) begin
                    n_code = 2'd3;
                end else begin
                    n_emit  = 1'b1;
                    n_state = LO;
                    n_acc   = '0;
                    n_dig   = 1'b0;
                end
            end
            n_state = n_code != 2'd0 ? ERR : n_done ? DONE : n_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LO;
            acc         <= '0;
            lo          <= '0;
            dig         <= 1'b0;
            bank_ctr    <= '0;
            addr_ctr    <= '0;
            range_count <= '0;
            wr_en       <= 1'b0;
            wr_bank     <= '0;
            wr_addr     <= '0;
            wr_lo       <= '0;
            wr_hi       <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            state <= n_state;
            acc   <= n_acc;
            lo    <= n_lo;
            dig   <= n_dig;
            wr_en <= n_emit;
            if (n_emit) begin
                wr_bank     <= bank_ctr;
                wr_addr     <= addr_ctr;
                wr_lo       <= lo;
                wr_hi       <= hi_val;
                range_count <= range_count + 1'b1;
                bank_ctr    <= bank_ctr == BANK_W'(VALUE_PARALLELISM - 1) ? '0 : bank_ctr + 1'b1;
                addr_ctr    <= bank_ctr == BANK_W'(VALUE_PARALLELISM - 1) ? addr_ctr + 1'b1 : addr_ctr;
            end
            if (n_state == DONE)
                done <= 1'b1;
            if (n_code != 2'd0) begin
                error    <= 1'b1;
                err_code <= n_code;
            end
        end
    end
endmodule

// File: tb/tb_range_input_loader.sv
// tb_range_input_loader: directed streams with a write scoreboard for two loader configurations
// Ports: none (instance a: P=2, W=64, D=512; instance b: P=1, W=8, D=2)
module tb_range_input_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   checks = 0;
    int   failures = 0;

    range_input_loader_if bus_a();
    range_input_loader_if bus_b();

    logic        a_wr_en, a_done, a_error;
    logic [0:0]  a_wr_bank;
    logic [8:0]  a_wr_addr;
    logic [63:0] a_wr_lo, a_wr_hi;
    logic [10:0] a_range_count;
    logic [1:0]  a_err_code;

    logic        b_wr_en, b_done, b_error;
    logic [0:0]  b_wr_bank;
    logic [0:0]  b_wr_addr;
    logic [7:0]  b_wr_lo, b_wr_hi;
    logic [1:0]  b_range_count;
    logic [1:0]  b_err_code;

    range_input_loader #(.VALUE_PARALLELISM(2), .VALUE_WIDTH(64), .MEM_DEPTH(512)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a),
        .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_addr(a_wr_addr), .wr_lo(a_wr_lo), .wr_hi(a_wr_hi),
        .range_count(a_range_count), .done(a_done), .error(a_error), .err_code(a_err_code)
    );

    range_input_loader #(.VALUE_PARALLELISM(1), .VALUE_WIDTH(8), .MEM_DEPTH(2)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b),
        .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_addr(b_wr_addr), .wr_lo(b_wr_lo), .wr_hi(b_wr_hi),
        .range_count(b_range_count), .done(b_done), .error(b_error), .err_code(b_err_code)
    );

    typedef struct {
        int          bank;
        int          addr;
        logic [63:0] lo;
        logic [63:0] hi;
        logic        done;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    wr_t ea, eb;

    function automatic wr_t mk(input int bank, input int addr, input logic [63:0] lo, input logic [63:0] hi, input logic done);
        wr_t w;
        w.bank = bank;
        w.addr = addr;
        w.lo   = lo;
        w.hi   = hi;
        w.done = done;
        return w;
    endfunction

    always @(negedge clk) begin
        if (a_wr_en) begin
            checks++;
            assert (qa.size() > 0) else begin
                failures++;
                $error("FAIL a_unexpected_write observed lo=%0d hi=%0d expected no write", a_wr_lo, a_wr_hi);
            end
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                checks++;
                assert (int'(a_wr_bank) == ea.bank && int'(a_wr_addr) == ea.addr && a_wr_lo === ea.lo &&
                        a_wr_hi === ea.hi && a_done === ea.done) else begin
                    failures++;
                    $error("FAIL a_write observed bank=%0d addr=%0d lo=%0d hi=%0d done=%0b expected bank=%0d addr=%0d lo=%0d hi=%0d done=%0b",
                           a_wr_bank, a_wr_addr, a_wr_lo, a_wr_hi, a_done, ea.bank, ea.addr, ea.lo, ea.hi, ea.done);
                end
            end
        end
        if (b_wr_en) begin
            checks++;
            assert (qb.size() > 0) else begin
                failures++;
                $error("FAIL b_unexpected_write observed lo=%0d hi=%0d expected no write", b_wr_lo, b_wr_hi);
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                checks++;
                assert (int'(b_wr_bank) == eb.bank && int'(b_wr_addr) == eb.addr && {56'b0, b_wr_lo} === eb.lo &&
                        {56'b0, b_wr_hi} === eb.hi && b_done === eb.done) else begin
                    failures++;
                    $error("FAIL b_write observed bank=%0d addr=%0d lo=%0d hi=%0d done=%0b expected bank=%0d addr=%0d lo=%0d hi=%0d done=%0b",
                           b_wr_bank, b_wr_addr, b_wr_lo, b_wr_hi, b_done, eb.bank, eb.addr, eb.lo, eb.hi, eb.done);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic l);
        if (sel) begin
            bus_b.in_valid = v;
            bus_b.in_data  = d;
            bus_b.in_last  = l;
        end else begin
            bus_a.in_valid = v;
            bus_a.in_data  = d;
            bus_a.in_last  = l;
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] ch, input bit last, input int gap);
        bit ok = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        drive(sel, 1'b1, ch, last);
        for (int i = 0; i < 8 && !ok; i++) begin
            ok = sel ? bus_b.in_ready : bus_a.in_ready;
            @(posedge clk);
            #1;
        end
        drive(sel, 1'b0, 8'h00, 1'b0);
        if (!ok)
            chk("handshake_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send_str(input bit sel, input string s, input bit last_end, input int gapmax);
        for (int i = 0; i < s.len(); i++)
            send(sel, s[i], last_end && i == s.len() - 1, gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
    endtask

    task automatic do_reset(input bit sel);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 64'(a_wr_en), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_error", 64'(a_error), 64'd0);
        chk("rst_err_code", 64'(a_err_code), 64'd0);
        chk("rst_range_count", 64'(a_range_count), 64'd0);
        chk("rst_wr_lo", a_wr_lo, 64'd0);
        chk("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        chk("rst_b_in_ready", 64'(bus_b.in_ready), 64'd1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        qa.push_back(mk(0, 0, 11, 22, 1'b0));
        qa.push_back(mk(1, 0, 95, 115, 1'b1));
        send_str(1'b0, "11-22,95-115\n", 1'b1, 0);
        settle();
        chk("t1_pending", 64'(qa.size()), 64'd0);
        chk("t1_done", 64'(a_done), 64'd1);
        chk("t1_range_count", 64'(a_range_count), 64'd2);
        chk("t1_error", 64'(a_error), 64'd0);
        chk("t1_in_ready", 64'(bus_a.in_ready), 64'd0);

        do_reset(1'b0);
        chk("t2_rst_range_count", 64'(a_range_count), 64'd0);
        qa.push_back(mk(0, 0, 5, 7, 1'b0));
        qa.push_back(mk(1, 0, 3, 3, 1'b1));
        send_str(1'b0, " 5 - 7 ,\015\n3-3", 1'b1, 2);
        settle();
        chk("t2_pending", 64'(qa.size()), 64'd0);
        chk("t2_done", 64'(a_done), 64'd1);
        chk("t2_range_count", 64'(a_range_count), 64'd2);

        do_reset(1'b0);
        send_str(1'b0, "9-3", 1'b0, 0);
        chk("t3_error_before", 64'(a_error), 64'd0);
        send(1'b0, ",", 1'b0, 0);
        chk("t3_error", 64'(a_error), 64'd1);
        chk("t3_err_code", 64'(a_err_code), 64'd1);
        settle();
        chk("t3_range_count", 64'(a_range_count), 64'd0);
        chk("t3_done", 64'(a_done), 64'd0);

        do_reset(1'b0);
        send_str(1'b0, "1-", 1'b0, 0);
        chk("t4_error_before", 64'(a_error), 64'd0);
        send(1'b0, "-", 1'b0, 0);
        chk("t4_error", 64'(a_error), 64'd1);
        chk("t4_err_code", 64'(a_err_code), 64'd1);
        chk("t4_in_ready", 64'(bus_a.in_ready), 64'd0);

        do_reset(1'b0);
        send_str(1'b0, "12-3", 1'b0, 0);
        do_reset(1'b0);
        qa.push_back(mk(0, 0, 4, 5, 1'b1));
        send_str(1'b0, "4-5", 1'b1, 0);
        settle();
        chk("t5_pending", 64'(qa.size()), 64'd0);
        chk("t5_range_count", 64'(a_range_count), 64'd1);
        chk("t5_done", 64'(a_done), 64'd1);

        send_str(1'b1, "30", 1'b0, 0);
        chk("t6_error_before", 64'(b_error), 64'd0);
        send(1'b1, "0", 1'b0, 0);
        chk("t6_error", 64'(b_error), 64'd1);
        chk("t6_err_code", 64'(b_err_code), 64'd2);
        chk("t6_in_ready", 64'(bus_b.in_ready), 64'd0);
        drive(1'b1, 1'b1, "-", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t6_err_code_hold", 64'(b_err_code), 64'd2);
        chk("t6_range_count", 64'(b_range_count), 64'd0);

        do_reset(1'b1);
        qb.push_back(mk(0, 0, 1, 2, 1'b0));
        qb.push_back(mk(0, 1, 3, 4, 1'b0));
        send_str(1'b1, "1-2,3-4,5-6", 1'b0, 0);
        chk("t7_error_before", 64'(b_error), 64'd0);
        send(1'b1, ",", 1'b0, 0);
        chk("t7_error", 64'(b_error), 64'd1);
        chk("t7_err_code", 64'(b_err_code), 64'd3);
        settle();
        chk("t7_range_count", 64'(b_range_count), 64'd2);
        chk("t7_pending", 64'(qb.size()), 64'd0);

        do_reset(1'b1);
        qb.push_back(mk(0, 0, 255, 255, 1'b1));
        send_str(1'b1, "255-255\n", 1'b1, 0);
        settle();
        chk("t8_pending", 64'(qb.size()), 64'd0);
        chk("t8_done", 64'(b_done), 64'd1);
        chk("t8_error", 64'(b_error), 64'd0);
        chk("t8_range_count", 64'(b_range_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/range_input_loader.md
Name: range_input_loader

Overview:
- Parses an ASCII puzzle-input byte stream of ranges `lo-hi` separated by `,` or newline into binary (lo, hi) pairs.
- Writes the pairs round-robin into the per-lane value memories that the range-checker lanes read.
- Is the writer side of those memories: lane i owns bank i.
- Reports completion and format, numeric or capacity errors to the top level.

Parameters:
- VALUE_PARALLELISM, 4, number of memory banks / checker lanes (>=1).
- VALUE_WIDTH, 64, width of lo/hi values.
- MEM_DEPTH, 512, entries per bank.
- COUNT_W, $clog2(VALUE_PARALLELISM*MEM_DEPTH)+1, width of range_count.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte valid.
- in_ready  out  1  loader accepts byte.
- in_data  in  8  ASCII byte.
- in_last  in  1  marks final byte of stream; qualified by in_valid.
- wr_en  out  1  one-cycle memory write strobe.
- wr_bank  out  $clog2(VALUE_PARALLELISM) (min 1)  target bank.
- wr_addr  out  $clog2(MEM_DEPTH)  entry within bank.
- wr_lo  out  VALUE_WIDTH  range low bound.
- wr_hi  out  VALUE_WIDTH  range high bound.
- range_count  out  COUNT_W  ranges written so far.
- done  out  1  sticky; stream fully consumed without error.
- error  out  1  sticky; parse aborted.
- err_code  out  2  0 none, 1 format, 2 numeric overflow, 3 memory full.

Behaviour:
- Reset: synchronous, active-high. The clock is clk and the reset is reset.
  - Next edge: state=LO, accumulators=0, digit flags=0, range_count=0.
  - wr_en=0, wr_bank/wr_addr/wr_lo/wr_hi=0, done=0, error=0, err_code=0.
  - Reset mid-stream discards the partial range. No write is issued after reset.
- Handshake: a byte is accepted on a cycle with in_valid && in_ready. in_ready = (state is LO or HI), a registered-state decode.
  - Writes never stall, so in_ready stays 1 until DONE or ERR.
- States: LO (parsing low bound), HI (parsing high bound), DONE, ERR. DONE and ERR are terminal until reset.
- Per accepted byte:
  - `0`-`9`: acc = acc*10 + digit; set the state's digit flag.
    - If the result exceeds 2^VALUE_WIDTH-1: go to ERR, err_code=2.
    - Overflow detection uses a VALUE_WIDTH+4-bit intermediate.
  - Space or `\r`: ignored in any state.
  - `-` in LO with digit flag set: latch lo, clear acc, go to HI.
  - `-` in LO without digits, or `-` in HI: ERR, err_code=1.
  - `,` or `\n` in HI with digits:
    - If lo > hi (unsigned): ERR, err_code=1.
    - Else if range_count == VALUE_PARALLELISM*MEM_DEPTH: ERR, err_code=3.
    - Else emit and return to LO.
  - `,` or `\n` in HI without digits: ERR, err_code=1.
  - `,` or `\n` in LO without digits: ignored (blank lines, trailing separators).
  - `,` or `\n` in LO with digits: ERR, err_code=1.
  - Any other byte: ERR, err_code=1.
- Emit: the cycle after the accepting edge:
  - wr_en=1 for exactly one cycle.
  - wr_bank = range_count mod VALUE_PARALLELISM.
  - wr_addr = range_count / VALUE_PARALLELISM.
  - wr_lo/wr_hi hold registered copies.
  - range_count increments on the same edge that asserts wr_en.
  - wr_* data holds its value until the next emit.
  - Back-to-back emits on consecutive bytes are legal.
- in_last: the byte is processed as above first, then:
  - If the resulting state is LO with no digits: DONE.
  - If it is HI with digits: an implicit terminator applies (same checks, emit), then DONE.
  - Otherwise: ERR, err_code=1.
  - done asserts on the same cycle as the final wr_en, or one cycle after the last handshake if nothing is emitted.
- Error:
  - error and err_code assert one cycle after the offending handshake.
  - No wr_en is issued for the offending range.
  - The first error wins; err_code does not change afterwards.
- in_valid with in_ready=0: the byte is not consumed. The producer must hold it (standard valid/ready).

Test Plan:
- P=2, stream "11-22,95-115\n" with in_last on `\n`:
  - wr bank0/addr0 lo=11 hi=22, then bank1/addr0 lo=95 hi=115.
  - done=1, range_count=2, error=0.
- P=2, " 5 - 7 ,\r\n3-3" with random in_valid gaps, in_last on final `3`:
  - writes (5,7) bank0/addr0 and (3,3) bank1/addr0.
  - done=1 on the cycle of the second wr_en.
- VALUE_WIDTH=8, "300-400,":
  - error=1, err_code=2 one cycle after the `0` that overflows.
  - no wr_en, in_ready=0 afterwards.
- P=1, MEM_DEPTH=2, "1-2,3-4,5-6,":
  - two writes (addr 0, 1), then err_code=3 on the third `,`.
  - range_count=2.
- "9-3," → err_code=1, no write. "1--2" → err_code=1 on the second `-`.
- Reset asserted after "12-3" is accepted, then stream "4-5" with in_last:
  - single write lo=4 hi=5 at bank0/addr0, range_count=1.
